nz_addr_gen: RTL and testbench

NZ_ADDR_GEN -- requirements
Module: nz_addr_gen

---
 rtl/nz_addr_gen.sv | 162 ++++++++++++++++
 tb/tb_nz_addr_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nz_addr_gen.sv
// Nonzero-address generator: scans a SPAD nonzero mask and issues up to MAC_DIM
// ascending entry indices per cycle. Optional macro NZ_ADDR_GEN_STATS_EN adds grp_count.
module nz_addr_gen #(
    parameter int MAC_DIM    = 5,
    parameter int SPAD_WIDTH = 64,
    parameter int ADDR_WIDTH = $clog2(SPAD_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [SPAD_WIDTH-1:0]         nz_mask,
    input  logic                          stall,
    output logic [ADDR_WIDTH*MAC_DIM-1:0] non_zero_add_out,
    output logic [2:0]                    non_zero_num,
    output logic                          acc,
    output logic                          done,
    output logic                          grp_vd,
    output logic                          busy
`ifdef NZ_ADDR_GEN_STATS_EN
    ,
    output logic [6:0]                    grp_count
`endif
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                          state_q, state_d;
    logic [SPAD_WIDTH-1:0]           rem_q, rem_d;
    logic [ADDR_WIDTH*MAC_DIM-1:0]   addr_q, addr_d;
    logic [2:0]                      num_q, num_d;
    logic                            acc_q, acc_d;
    logic                            done_q, done_d;
    logic                            vd_q, vd_d;
    logic                            busy_q, busy_d;
    logic                            first_q, first_d;
`ifdef NZ_ADDR_GEN_STATS_EN
    logic [6:0]                      cnt_q, cnt_d;
`endif

    // Group extraction from the remaining mask
    logic [SPAD_WIDTH-1:0]           pick_mask;
    logic [ADDR_WIDTH*MAC_DIM-1:0]   grp_addr;
    logic [2:0]                      grp_num;
    logic [ADDR_WIDTH-1:0]           lane_idx;
    logic                            found;
    int                              grp_cnt;

    always_comb begin
        pick_mask = rem_q;
        grp_addr  = '0;
        grp_cnt   = 0;
        lane_idx  = '0;
        found     = 1'b0;
        for (int j = 0; j < MAC_DIM; j++) begin
            lane_idx = '0;
            found    = 1'b0;
            for (int i = 0; i < SPAD_WIDTH; i++) begin
                if (!found && pick_mask[i]) begin
                    lane_idx = ADDR_WIDTH'(i);
                    found    = 1'b1;
                end
            end
            if (found) begin
                grp_addr[j*ADDR_WIDTH +: ADDR_WIDTH] = lane_idx;
                // clear the lowest set bit just taken
                pick_mask = pick_mask & (pick_mask - SPAD_WIDTH'(1));
                grp_cnt   = grp_cnt + 1;
            end
        end
        grp_num = (grp_cnt == 0) ? 3'd0 : 3'(grp_cnt - 1);
    end

    // busy stays high through the cycle that shows done; the IDLE cycle that
    // follows clears it, which also blocks a start presented alongside done.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        num_d   = num_q;
        acc_d   = acc_q;
        done_d  = done_q;
        vd_d    = vd_q;
        busy_d  = busy_q;
        first_d = first_q;
`ifdef NZ_ADDR_GEN_STATS_EN
        cnt_d   = cnt_q;
`endif
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    vd_d   = 1'b0;
                    done_d = 1'b0;
                    busy_d = 1'b0;
                    if (start && !busy_q) begin
                        rem_d   = nz_mask;
                        busy_d  = 1'b1;
                        first_d = 1'b1;
                        state_d = SCAN;
`ifdef NZ_ADDR_GEN_STATS_EN
                        cnt_d   = '0;
`endif
                    end
                end
                SCAN: begin
                    addr_d  = grp_addr;
                    num_d   = grp_num;
                    acc_d   = !first_q;
                    first_d = 1'b0;
                    vd_d    = 1'b1;
                    rem_d   = pick_mask;
                    done_d  = (pick_mask == '0);
`ifdef NZ_ADDR_GEN_STATS_EN
                    cnt_d   = cnt_q + 7'd1;
`endif
                    if (pick_mask == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            addr_q  <= '0;
            num_q   <= '0;
            acc_q   <= 1'b0;
            done_q  <= 1'b0;
            vd_q    <= 1'b0;
            busy_q  <= 1'b0;
            first_q <= 1'b0;
`ifdef NZ_ADDR_GEN_STATS_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            vd_q    <= vd_d;
            busy_q  <= busy_d;
            first_q <= first_d;
`ifdef NZ_ADDR_GEN_STATS_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign non_zero_add_out = addr_q;
    assign non_zero_num     = num_q;
    assign acc              = acc_q;
    assign done             = done_q;
    assign grp_vd           = vd_q;
    assign busy             = busy_q;
`ifdef NZ_ADDR_GEN_STATS_EN
    assign grp_count        = cnt_q;
`endif

endmodule

// File: tb/tb_nz_addr_gen.sv
// Directed self-checking bench for nz_addr_gen (default parameters; grp_count
// is checked when NZ_ADDR_GEN_STATS_EN is defined).
module tb_nz_addr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] nz_mask;
    logic        stall;
    logic [29:0] non_zero_add_out;
    logic [2:0]  non_zero_num;
    logic        acc, done, grp_vd, busy;
`ifdef NZ_ADDR_GEN_STATS_EN
    logic [6:0]  grp_count;
`endif

    int tests  = 0;
    int failed = 0;

    nz_addr_gen dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .nz_mask          (nz_mask),
        .stall            (stall),
        .non_zero_add_out (non_zero_add_out),
        .non_zero_num     (non_zero_num),
        .acc              (acc),
        .done             (done),
        .grp_vd           (grp_vd),
        .busy             (busy)
`ifdef NZ_ADDR_GEN_STATS_EN
        ,
        .grp_count        (grp_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [63:0] m);
        nz_mask = m;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // {grp_vd, done, acc, num, addr} packed for compact comparisons
    function automatic logic [35:0] grp(input logic v, input logic d, input logic a,
                                        input logic [2:0] n,
                                        input logic [5:0] l4, input logic [5:0] l3,
                                        input logic [5:0] l2, input logic [5:0] l1,
                                        input logic [5:0] l0);
        return {v, d, a, n, l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [35:0] obs();
        return {grp_vd, done, acc, non_zero_num, non_zero_add_out};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stall = 1'b0; nz_mask = '0;
        tick(); tick();
        tests++;
        if ({obs(), busy} !== 37'd0) begin
            failed++;
            $display("FAIL reset_outputs: got %h expected 0", {obs(), busy});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_eight_bits();
        logic [35:0] e;
        launch(64'h0000_0000_0000_00FF);
        tests++;
        if (busy !== 1'b1 || grp_vd !== 1'b0) begin
            failed++;
            $display("FAIL ff_accept: got busy=%b vd=%b expected busy=1 vd=0", busy, grp_vd);
        end
        tick();
        e = grp(1, 0, 0, 3'd4, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0);
        tests++;
        if (obs() !== e) begin
            failed++;
            $display("FAIL ff_group1: got %h expected %h", obs(), e);
        end
        tick();
        e = grp(1, 1, 1, 3'd2, 6'd0, 6'd0, 6'd7, 6'd6, 6'd5);
        tests++;
        if (obs() !== e || busy !== 1'b1) begin
            failed++;
            $display("FAIL ff_group2: got %h busy=%b expected %h busy=1", obs(), busy, e);
        end
        tick();
        tests++;
        if (grp_vd !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failed++;
            $display("FAIL ff_idle: got vd=%b busy=%b done=%b expected 0 0 0", grp_vd, busy, done);
        end
    endtask

    task automatic test_zero_mask();
        logic [35:0] e;
        launch(64'h0);
        tick();
        e = grp(1, 1, 0, 3'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        tests++;
        if (obs() !== e) begin
            failed++;
            $display("FAIL zero_group: got %h expected %h", obs(), e);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || grp_vd !== 1'b0) begin
            failed++;
            $display("FAIL zero_busy: got busy=%b vd=%b expected 0 0", busy, grp_vd);
        end
    endtask

    task automatic test_end_bits();
        logic [35:0] e;
        launch(64'h8000_0000_0000_0001);
        tick();
        e = grp(1, 1, 0, 3'd1, 6'd0, 6'd0, 6'd0, 6'd63, 6'd0);
        tests++;
        if (obs() !== e) begin
            failed++;
            $display("FAIL endbits_group: got %h expected %h", obs(), e);
        end
        tick();
    endtask

    // Runs an all-ones job; optionally pulses start mid-job, which must be ignored.
    task automatic test_all_ones(input logic poke_start);
        logic [35:0] e;
        int groups = 0;
        int budget = 0;
        logic [35:0] last = '0;
        launch({64{1'b1}});
        while (budget < 30) begin
            tick();
            budget++;
            if (grp_vd) begin
                groups++;
                last = obs();
                if (groups == 2) begin
                    e = grp(1, 0, 1, 3'd4, 6'd9, 6'd8, 6'd7, 6'd6, 6'd5);
                    tests++;
                    if (obs() !== e) begin
                        failed++;
                        $display("FAIL ones_group2: got %h expected %h", obs(), e);
                    end
                    if (poke_start) begin
                        nz_mask = 64'h0;
                        start   = 1'b1;
                    end
                end else begin
                    start = 1'b0;
                end
                if (done) break;
            end
        end
        start = 1'b0;
        e = grp(1, 1, 1, 3'd3, 6'd0, 6'd63, 6'd62, 6'd61, 6'd60);
        tests++;
        if (groups !== 13 || last !== e) begin
            failed++;
            $display("FAIL ones_groups: got %0d groups last=%h expected 13 last=%h", groups, last, e);
        end
`ifdef NZ_ADDR_GEN_STATS_EN
        tests++;
        if (grp_count !== 7'd13) begin
            failed++;
            $display("FAIL ones_grp_count: got %0d expected 13", grp_count);
        end
`endif
        tick();
        tests++;
        if (busy !== 1'b0 || grp_vd !== 1'b0) begin
            failed++;
            $display("FAIL ones_idle: got busy=%b vd=%b expected 0 0", busy, grp_vd);
        end
    endtask

    task automatic test_stall();
        logic [35:0] e1, e2;
        e1 = grp(1, 0, 0, 3'd4, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0);
        e2 = grp(1, 1, 1, 3'd2, 6'd0, 6'd0, 6'd7, 6'd6, 6'd5);
        launch(64'h0000_0000_0000_00FF);
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (obs() !== e1 || busy !== 1'b1) begin
                failed++;
                $display("FAIL stall_g1_hold%0d: got %h expected %h", k, obs(), e1);
            end
        end
        stall = 1'b0;
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (obs() !== e2 || busy !== 1'b1) begin
                failed++;
                $display("FAIL stall_g2_hold%0d: got %h busy=%b expected %h busy=1", k, obs(), busy, e2);
            end
        end
        stall = 1'b0;
        tick();
        tests++;
        if (grp_vd !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL stall_release: got vd=%b busy=%b expected 0 0", grp_vd, busy);
        end
    endtask

    task automatic test_start_on_done();
        launch(64'h0);
        tick();
        nz_mask = 64'h1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0 || grp_vd !== 1'b0) begin
            failed++;
            $display("FAIL start_on_done: got busy=%b vd=%b expected 0 0", busy, grp_vd);
        end
    endtask

    task automatic test_reset_mid_job();
        logic [35:0] e;
        int seen = 0;
        launch({64{1'b1}});
        tick();
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({obs(), busy} !== 37'd0) begin
            failed++;
            $display("FAIL midreset_clear: got %h expected 0", {obs(), busy});
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (grp_vd || busy) seen++;
        end
        tests++;
        if (seen !== 0) begin
            failed++;
            $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen);
        end
        launch(64'h1);
        tick();
        e = grp(1, 1, 0, 3'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        tests++;
        if (obs() !== e) begin
            failed++;
            $display("FAIL midreset_restart: got %h expected %h", obs(), e);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_eight_bits();
        test_zero_mask();
        test_end_bits();
        test_all_ones(1'b0);
        test_all_ones(1'b1);
        test_stall();
        test_start_on_done();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
